// File: rtl/conv3x3_sequencer_if.sv
// conv3x3_sequencer_if: request, MAC-side and result signals of the 3x3 convolution sequencer.
// master = requester/MAC environment, slave = the sequencer itself.
interface conv3x3_sequencer_if;
    logic        start;
    logic        abort;
    logic [71:0] window;
    logic [71:0] kernel;
    logic        ready;
    logic        busy;
    logic        mac_clear;
    logic        mac_enable;
    logic [7:0]  mac_value_a;
    logic [7:0]  mac_value_b;
    logic [7:0]  mac_result;
    logic [7:0]  pixel_out;
    logic        pixel_valid;
    logic [15:0] pixel_count;
    modport master (
        output start, abort, window, kernel, mac_result,
        input  ready, busy, mac_clear, mac_enable, mac_value_a, mac_value_b,
               pixel_out, pixel_valid, pixel_count
    );
    modport slave (
        input  start, abort, window, kernel, mac_result,
        output ready, busy, mac_clear, mac_enable, mac_value_a, mac_value_b,
               pixel_out, pixel_valid, pixel_count
    );
endinterface

// File: rtl/conv3x3_sequencer.sv
// conv3x3_sequencer: steps an external saturating MAC through the nine taps of a 3x3 window.
// One result per 12 cycles: start, CLEAR, nine ACCUM taps, SETTLE, capture.
module conv3x3_sequencer (
    input logic                  clock,
    input logic                  reset_n,
    conv3x3_sequencer_if.slave   bus
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] CLEAR  = 2'd1;
    localparam logic [1:0] ACCUM  = 2'd2;
    localparam logic [1:0] SETTLE = 2'd3;
    logic [1:0]  state_q, state_d;
    logic [3:0]  tap_q, tap_d;
    logic [71:0] win_q, win_d, ker_q, ker_d;
    logic [7:0]  pix_q, pix_d;
    logic        valid_q, valid_d;
    logic [15:0] cnt_q, cnt_d;
    logic        in_idle, in_accum, take, last, capture;
    assign in_idle  = state_q == IDLE;
    assign in_accum = state_q == ACCUM;
    assign take     = in_idle && bus.start;
    assign last     = tap_q == 4'd8;
    assign capture  = state_q == SETTLE && !bus.abort;
    // start wins over abort in IDLE; abort only matters once an operation is in flight
    always_comb begin
        state_d = take                     ? CLEAR  :
                  (!in_idle && bus.abort)  ? IDLE   :
                  state_q == CLEAR         ? ACCUM  :
                  (in_accum && last)       ? SETTLE :
                  state_q == SETTLE        ? IDLE   : state_q;
        tap_d   = (in_accum && !bus.abort && !last) ? tap_q + 4'd1 : 4'd0;
        win_d   = take ? bus.window : win_q;
        ker_d   = take ? bus.kernel : ker_q;
        pix_d   = capture ? bus.mac_result : pix_q;
        valid_d = capture;
        cnt_d   = cnt_q + {15'd0, capture};
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            tap_q   <= 4'd0;
            win_q   <= 72'd0;
            ker_q   <= 72'd0;
            pix_q   <= 8'd0;
            valid_q <= 1'b0;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            tap_q   <= tap_d;
            win_q   <= win_d;
            ker_q   <= ker_d;
            pix_q   <= pix_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end
    assign bus.ready       = in_idle;
    assign bus.busy        = !in_idle;
    assign bus.mac_clear   = state_q == CLEAR;
    assign bus.mac_enable  = in_accum;
    assign bus.mac_value_a = in_accum ? win_q[{tap_q, 3'b000} +: 8] : 8'd0;
    assign bus.mac_value_b = in_accum ? ker_q[{tap_q, 3'b000} +: 8] : 8'd0;
    assign bus.pixel_out   = pix_q;
    assign bus.pixel_valid = valid_q;
    assign bus.pixel_count = cnt_q;
endmodule

// File: tb/tb_conv3x3_sequencer.sv
// tb_conv3x3_sequencer: directed stimulus with a saturating MAC model and a cycle-level reference
// model that predicts every sequencer output from the latched operands and elapsed cycles.
module tb_conv3x3_sequencer;
    localparam logic [71:0] SOBEL = 72'h01_00_FF_02_00_FE_01_00_FF;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   acc = 777;
    conv3x3_sequencer_if bus();
    conv3x3_sequencer dut (.clock(clk), .reset_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    function automatic int clamp(int s);
        return s < 0 ? 0 : (s > 255 ? 255 : s);
    endfunction
    function automatic int conv(logic [71:0] w, logic [71:0] k);
        int s = 0;
        for (int i = 0; i < 9; i++) begin
            logic [7:0] p;
            logic signed [7:0] c;
            p = w[8*i +: 8];
            c = $signed(k[8*i +: 8]);
            s += int'(p) * int'(c);
        end
        return clamp(s);
    endfunction
    function automatic logic [71:0] cols(int l, int m, int r);
        logic [71:0] w;
        for (int i = 0; i < 9; i++)
            w[8*i +: 8] = (i % 3 == 0) ? 8'(l) : ((i % 3 == 1) ? 8'(m) : 8'(r));
        return w;
    endfunction
    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0d exp=%0d at %0t", nm, act, exp, $time);
        end
    endtask
    // MAC is deliberately not reset, so a skipped clear would leak a stale sum
    always @(posedge clk)
        if (bus.mac_clear) acc <= 0;
        else if (bus.mac_enable) acc <= acc + int'(bus.mac_value_a) * int'($signed(bus.mac_value_b));
    assign bus.mac_result = 8'(clamp(acc));
    logic        m_busy, m_valid;
    int          m_age;
    logic [71:0] m_win, m_ker;
    logic [7:0]  m_pix;
    logic [15:0] m_cnt;
    always @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            m_busy <= 0; m_age <= 0; m_valid <= 0; m_pix <= 0; m_cnt <= 0; m_win <= 0; m_ker <= 0;
        end else begin
            m_valid <= 0;
            if (!m_busy) begin
                if (bus.start) begin
                    m_busy <= 1; m_age <= 0; m_win <= bus.window; m_ker <= bus.kernel;
                end
            end else if (bus.abort) m_busy <= 0;
            else if (m_age == 10) begin
                m_busy <= 0; m_valid <= 1; m_pix <= 8'(conv(m_win, m_ker)); m_cnt <= m_cnt + 16'd1;
            end else m_age <= m_age + 1;
        end
    always @(negedge clk)
        if (rst_n) begin
            logic in_acc;
            logic [7:0] ea, eb;
            in_acc = m_busy && m_age >= 1 && m_age <= 9;
            ea = in_acc ? m_win[8*(m_age-1) +: 8] : 8'd0;
            eb = in_acc ? m_ker[8*(m_age-1) +: 8] : 8'd0;
            chk("ready", 32'(bus.ready), 32'(!m_busy));
            chk("busy", 32'(bus.busy), 32'(m_busy));
            chk("mac_clear", 32'(bus.mac_clear), 32'(m_busy && m_age == 0));
            chk("mac_enable", 32'(bus.mac_enable), 32'(in_acc));
            chk("mac_value_a", 32'(bus.mac_value_a), 32'(ea));
            chk("mac_value_b", 32'(bus.mac_value_b), 32'(eb));
            chk("pixel_valid", 32'(bus.pixel_valid), 32'(m_valid));
            chk("pixel_out", 32'(bus.pixel_out), 32'(m_pix));
            chk("pixel_count", 32'(bus.pixel_count), 32'(m_cnt));
        end
    task automatic launch(logic [71:0] w, logic [71:0] k, logic ab);
        bus.start = 1; bus.abort = ab; bus.window = w; bus.kernel = k;
        @(negedge clk);
        bus.start = 0; bus.abort = 0;
        bus.window = {8'($urandom), 32'($urandom), 32'($urandom)};
        bus.kernel = {8'($urandom), 32'($urandom), 32'($urandom)};
        chk("clear_first", 32'(bus.mac_clear), 1);
        chk("busy_after_start", 32'(bus.busy), 1);
    endtask
    task automatic await_px(int exp_pix, int exp_cnt, int left);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.pixel_valid && n < 20);
        chk("latency", n, left);
        chk("lit_valid", 32'(bus.pixel_valid), 1);
        chk("lit_pixel", 32'(bus.pixel_out), exp_pix);
        chk("lit_count", 32'(bus.pixel_count), exp_cnt);
    endtask
    initial begin
        bus.start = 0; bus.abort = 0; bus.window = 0; bus.kernel = 0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(bus.ready), 1);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_pixel", 32'(bus.pixel_out), 0);
        chk("rst_count", 32'(bus.pixel_count), 0);
        chk("rst_mac_enable", 32'(bus.mac_enable), 0);
        #1 rst_n = 1;
        @(negedge clk);
        launch(cols(10, 99, 50), SOBEL, 0);  await_px(160, 1, 11);
        launch(cols(0, 33, 200), SOBEL, 0);  await_px(255, 2, 11);
        launch(cols(200, 7, 0), SOBEL, 0);   await_px(0, 3, 11);
        launch(cols(20, 77, 30), SOBEL, 0);
        repeat (5) @(negedge clk);
        bus.start = 1; bus.window = cols(0, 0, 200);
        @(negedge clk);
        bus.start = 0;
        await_px(40, 4, 5);
        launch(cols(0, 0, 200), SOBEL, 0);   await_px(255, 5, 11);
        launch(cols(10, 99, 50), SOBEL, 0);
        repeat (4) @(negedge clk);
        bus.abort = 1;
        @(negedge clk);
        bus.abort = 0;
        chk("abort_ready", 32'(bus.ready), 1);
        chk("abort_count", 32'(bus.pixel_count), 5);
        bus.abort = 1;
        repeat (12) begin
            @(negedge clk);
            chk("abort_no_valid", 32'(bus.pixel_valid), 0);
        end
        chk("idle_abort_ready", 32'(bus.ready), 1);
        launch(cols(10, 99, 50), SOBEL, 1);  await_px(160, 6, 11);
        launch(cols(0, 33, 200), SOBEL, 0);
        repeat (4) @(negedge clk);
        #2 rst_n = 0;
        #1;
        chk("arst_ready", 32'(bus.ready), 1);
        chk("arst_busy", 32'(bus.busy), 0);
        chk("arst_mac_enable", 32'(bus.mac_enable), 0);
        chk("arst_mac_clear", 32'(bus.mac_clear), 0);
        chk("arst_pixel", 32'(bus.pixel_out), 0);
        chk("arst_count", 32'(bus.pixel_count), 0);
        @(negedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        launch(cols(10, 99, 50), SOBEL, 0);  await_px(160, 1, 11);
        repeat (3) @(negedge clk);
        chk("hold_pixel", 32'(bus.pixel_out), 160);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/conv3x3_sequencer.md
CONV3X3_SEQUENCER -- requirements
Module: conv3x3_sequencer

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed as listed below.
REQ-002 clock  in  1  sole clock; all state changes on its rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 start  in  1  request one 3x3 convolution; accepted only while ready=1.
REQ-005 abort  in  1  synchronous cancel of an in-flight convolution.
REQ-006 window  in  72  nine unsigned 8-bit pixels; tap i = bits [8i+7:8i], i=0 top-left, row-major.
REQ-007 kernel  in  72  nine signed 8-bit coefficients, same packing as window.
REQ-008 ready  out  1  high in IDLE only.
REQ-009 busy  out  1  inverse of ready.
REQ-010 mac_clear  out  1  drives the accumulator's clear.
REQ-011 mac_enable  out  1  drives the accumulator's enable.
REQ-012 mac_value_a  out  8  unsigned pixel operand for the current tap.
REQ-013 mac_value_b  out  8  signed coefficient operand for the current tap.
REQ-014 mac_result  in  8  saturated (0..255) accumulator result returned by the MAC.
REQ-015 pixel_out  out  8  registered convolution result.
REQ-016 pixel_valid  out  1  one-cycle pulse; pixel_out is valid while it is high.
REQ-017 pixel_count  out  16  number of pixel_valid pulses since reset.

Function
REQ-018 The FSM SHALL have states IDLE, CLEAR, ACCUM, SETTLE.
REQ-019 IDLE -> CLEAR on the edge where start=1. window and kernel SHALL be latched into internal registers on that edge; later input changes have no effect on the running operation.
REQ-020 CLEAR lasts exactly one cycle with mac_clear=1 and mac_enable=0, then moves to ACCUM with tap index 0.
REQ-021 ACCUM lasts exactly nine cycles with mac_enable=1 and mac_clear=0.
REQ-022 In ACCUM, mac_value_a and mac_value_b SHALL present latched tap[tap index]; tap index increments 0..8 each cycle; after tap 8 the FSM moves to SETTLE.
REQ-023 In SETTLE (one cycle), the edge leaving SETTLE SHALL load pixel_out<=mac_result, set pixel_valid=1 for one cycle, increment pixel_count, and return to IDLE.
REQ-024 Latency: pixel_valid SHALL be high in the 11th cycle after the start-acceptance edge (edges E1 = CLEAR->ACCUM, E2..E10 = accumulate, E11 = capture).
REQ-025 mac_clear, mac_enable, mac_value_a, mac_value_b, ready and busy SHALL be Moore decodes of the state and tap registers only.
REQ-026 Outside ACCUM, mac_value_a and mac_value_b SHALL be 0.
REQ-027 start while busy SHALL be ignored: nothing is queued, no error is flagged, and the latched operands are not altered.
REQ-028 A new start in the same cycle pixel_valid is high SHALL be accepted (ready is already 1); back-to-back throughput is one result per 12 cycles.
REQ-029 abort=1 in CLEAR, ACCUM or SETTLE SHALL force IDLE on the next edge with no pixel_valid and no pixel_count change; abort SHALL be ignored in IDLE.
REQ-030 Simultaneous start and abort in IDLE SHALL start the operation.
REQ-031 pixel_out SHALL hold its value between pulses.
REQ-032 pixel_count SHALL wrap from 65535 to 0.

Reset
REQ-033 reset_n=0 SHALL immediately put the FSM in IDLE and set tap index, latched operands, pixel_out, pixel_count and pixel_valid to 0. It SHALL also force mac_clear=0, mac_enable=0, ready=1 and busy=0, whether or not an operation is in flight.
REQ-034 After reset_n deasserts, the first start SHALL again drive a CLEAR cycle before any accumulation, so a stale accumulator value never leaks into a result.

Verification
REQ-035 Kernel {-1,0,1,-2,0,2,-1,0,1}, left column pixels 10, right column 50, start pulse: pixel_valid 11 cycles later with pixel_out=160, pixel_count=1.
REQ-036 Same kernel, left column 0, right column 200: pixel_out=255 (saturated).
REQ-037 Same kernel, left column 200, right column 0: pixel_out=0 (negative clamp).
REQ-038 start pulsed in ACCUM tap 4 with a different window: ignored, and the result matches the first window only.
REQ-039 abort in ACCUM tap 3: IDLE next cycle, no pixel_valid, pixel_count unchanged; the next start gives a correct result.
REQ-040 reset_n low during ACCUM: outputs zero asynchronously, and a later start produces a correct result with mac_clear pulsed first.
